// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C byte-transaction core
// among NUM_CLIENTS (2..4) requesters.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cl_req/cl_rw      per-client request level and read(1)/write(0) flag
//   cl_dev/reg/wdata  per-client command bytes, client i at [8i+7:8i]
//   cl_ack            one-cycle completion pulse to the owning client
//   cl_err            with cl_ack: 1 = transaction aborted on timeout
//   cl_rdata          last completed read byte (held until next read)
//   busy              high from grant until the inter-transaction gap ends
//   core_wr_req/rd_req level requests to the core, held until done
//   core_dev/reg/wdata latched command, stable for the whole transaction
//   core_wr_done/rd_done/rd_data  completion pulses and read byte from core
//
// Optional feature macro I2C_ARB_TIMEOUT_EN: when defined, a transaction
// left BUSY for TIMEOUT_CYCLES without a matching done is aborted.
module i2c_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int GAP_CYCLES     = 125,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CLIENTS-1:0]   cl_req,
    input  logic [NUM_CLIENTS-1:0]   cl_rw,
    input  logic [8*NUM_CLIENTS-1:0] cl_dev,
    input  logic [8*NUM_CLIENTS-1:0] cl_reg,
    input  logic [8*NUM_CLIENTS-1:0] cl_wdata,
    output logic [NUM_CLIENTS-1:0]   cl_ack,
    output logic                     cl_err,
    output logic [7:0]               cl_rdata,
    output logic                     busy,
    output logic                     core_wr_req,
    output logic                     core_rd_req,
    output logic [7:0]               core_dev,
    output logic [7:0]               core_reg,
    output logic [7:0]               core_wdata,
    input  logic                     core_wr_done,
    input  logic                     core_rd_done,
    input  logic [7:0]               core_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_GAP
    } state_e;

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [1:0]  OWN_LAST = 2'(NUM_CLIENTS - 1);

    state_e      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  own_q, own_d;
    logic        rw_q, rw_d;
    logic [7:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        wr_req_q, wr_req_d;
    logic        rd_req_q, rd_req_d;
    logic [3:0]  ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] gap_q, gap_d;

    // Requests padded to the fixed 2-bit index space; absent clients read 0.
    logic [3:0]  req4;
    logic [3:0]  rw4;
    logic [31:0] dev32, reg32, wdata32;

    assign req4    = 4'(cl_req);
    assign rw4     = 4'(cl_rw);
    assign dev32   = 32'(cl_dev);
    assign reg32   = 32'(cl_reg);
    assign wdata32 = 32'(cl_wdata);

    logic        gnt_vld;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand;
    logic [1:0]  own_nxt;
    logic        done_ok;
    logic        timeout;
    logic        take;

    // First set request at or above the rr pointer, wrapping at NUM_CLIENTS.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (int'(rr_q) + k >= NUM_CLIENTS) begin
                cand = 2'(int'(rr_q) + k - NUM_CLIENTS);
            end else begin
                cand = 2'(int'(rr_q) + k);
            end
            if (!gnt_vld && req4[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign own_nxt = (own_q == OWN_LAST) ? 2'd0 : own_q + 2'd1;
    assign done_ok = rw_q ? core_rd_done : core_wr_done;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tcnt_q, tcnt_d;

    // Zero outside BUSY, so it is already clear on entry to BUSY.
    always_comb begin
        tcnt_d = 16'd0;
        if (state_q == S_BUSY) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= 16'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign timeout = (tcnt_q == TO_LAST);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        own_d    = own_q;
        rw_d     = rw_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        ack_d    = 4'd0;
        err_d    = 1'b0;
        gap_d    = gap_q;
        take     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                take = gnt_vld;
            end
            S_BUSY: begin
                if (done_ok || timeout) begin
                    ack_d[own_q] = 1'b1;
                    err_d        = !done_ok;
                    if (done_ok && rw_q) begin
                        rdata_d = core_rd_data;
                    end
                    rr_d    = own_nxt;
                    gap_d   = 16'd0;
                    state_d = S_GAP;
                end else begin
                    wr_req_d = !rw_q;
                    rd_req_d = rw_q;
                end
            end
            S_GAP: begin
                // Last gap cycle doubles as the arbitration cycle, so
                // busy stays high when work is already queued.
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    take    = gnt_vld;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take) begin
            state_d = S_BUSY;
            own_d   = gnt_idx;
            rw_d    = rw4[gnt_idx];
            dev_d   = dev32[{gnt_idx, 3'b000} +: 8];
            reg_d   = reg32[{gnt_idx, 3'b000} +: 8];
            wdata_d = wdata32[{gnt_idx, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_q     <= 2'd0;
            own_q    <= 2'd0;
            rw_q     <= 1'b0;
            dev_q    <= 8'd0;
            reg_q    <= 8'd0;
            wdata_q  <= 8'd0;
            rdata_q  <= 8'd0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            ack_q    <= 4'd0;
            err_q    <= 1'b0;
            gap_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            own_q    <= own_d;
            rw_q     <= rw_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            gap_q    <= gap_d;
        end
    end

    assign cl_ack      = ack_q[NUM_CLIENTS-1:0];
    assign cl_err      = err_q;
    assign cl_rdata    = rdata_q;
    assign busy        = (state_q != S_IDLE);
    assign core_wr_req = wr_req_q;
    assign core_rd_req = rd_req_q;
    assign core_dev    = dev_q;
    assign core_reg    = reg_q;
    assign core_wdata  = wdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed stimulus for i2c_arbiter with an ack scoreboard
// checked by an independent monitor process.
module tb_i2c_arbiter;

    localparam int N   = 4;
    localparam int GAP = 125;
    localparam int TO  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cl_req = '0;
    logic [3:0]  cl_rw = '0;
    logic [31:0] cl_dev = '0;
    logic [31:0] cl_reg = '0;
    logic [31:0] cl_wdata = '0;
    logic [3:0]  cl_ack;
    logic        cl_err;
    logic [7:0]  cl_rdata;
    logic        busy;
    logic        core_wr_req;
    logic        core_rd_req;
    logic [7:0]  core_dev;
    logic [7:0]  core_reg;
    logic [7:0]  core_wdata;
    logic        core_wr_done = 1'b0;
    logic        core_rd_done = 1'b0;
    logic [7:0]  core_rd_data = '0;

    always #5 clk = ~clk;

    i2c_arbiter #(
        .NUM_CLIENTS   (N),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cl_req      (cl_req),
        .cl_rw       (cl_rw),
        .cl_dev      (cl_dev),
        .cl_reg      (cl_reg),
        .cl_wdata    (cl_wdata),
        .cl_ack      (cl_ack),
        .cl_err      (cl_err),
        .cl_rdata    (cl_rdata),
        .busy        (busy),
        .core_wr_req (core_wr_req),
        .core_rd_req (core_rd_req),
        .core_dev    (core_dev),
        .core_reg    (core_reg),
        .core_wdata  (core_wdata),
        .core_wr_done(core_wr_done),
        .core_rd_done(core_rd_done),
        .core_rd_data(core_rd_data)
    );

    typedef struct {
        logic [3:0] ack;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       overlap = 1'b0;
    logic       busy_low = 1'b0;
    logic [7:0] exp_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input int c, input logic err);
        exp_t e;
        e.ack   = 4'(1 << c);
        e.err   = err;
        e.rdata = exp_rdata;
        sb.push_back(e);
    endtask

    task automatic set_client(input int c, input logic rw, input logic [7:0] dv,
                              input logic [7:0] rg, input logic [7:0] wd);
        cl_rw[c]            = rw;
        cl_dev[8*c +: 8]    = dv;
        cl_reg[8*c +: 8]    = rg;
        cl_wdata[8*c +: 8]  = wd;
    endtask

    task automatic wait_req(input int limit, output int cyc);
        cyc = 0;
        while (!(core_wr_req || core_rd_req) && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_low = 1'b1;
        end
        chk("core_req_seen", 32'(core_wr_req | core_rd_req), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int cyc;
        cyc = 0;
        while (busy && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic pulse_wr();
        core_wr_done = 1'b1;
        @(negedge clk);
        core_wr_done = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        core_rd_done = 1'b1;
        core_rd_data = d;
        @(negedge clk);
        core_rd_done = 1'b0;
        core_rd_data = 8'h00;
    endtask

    // Monitor: every ack must match the oldest expected completion.
    always @(negedge clk) begin
        if (cl_ack !== 4'b0000) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: got ack=%b err=%b, required no ack",
                         cl_ack, cl_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cl_ack !== e.ack || cl_err !== e.err || cl_rdata !== e.rdata) begin
                    n_err++;
                    $display("FAIL ack_scoreboard: got ack=%b err=%b rdata=%h, required ack=%b err=%b rdata=%h",
                             cl_ack, cl_err, cl_rdata, e.ack, e.err, e.rdata);
                end
            end
        end
        if (core_wr_req && core_rd_req) overlap = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int c;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(cl_ack), 32'd0);
        chk("rst_err", 32'(cl_err), 32'd0);
        chk("rst_rdata", 32'(cl_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_core_req", 32'({core_wr_req, core_rd_req}), 32'd0);
        chk("rst_core_dev", 32'(core_dev), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write from client 1
        set_client(1, 1'b0, 8'hA0, 8'h10, 8'h5A);
        cl_req[1] = 1'b1;
        @(negedge clk);
        chk("t1_busy_at_grant", 32'(busy), 32'd1);
        chk("t1_req_not_yet", 32'(core_wr_req), 32'd0);
        @(negedge clk);
        chk("t1_wr_req", 32'(core_wr_req), 32'd1);
        chk("t1_rd_req", 32'(core_rd_req), 32'd0);
        chk("t1_dev", 32'(core_dev), 32'hA0);
        chk("t1_reg", 32'(core_reg), 32'h10);
        chk("t1_wdata", 32'(core_wdata), 32'h5A);
        set_client(1, 1'b1, 8'hFF, 8'hEE, 8'hDD);
        repeat (98) @(negedge clk);
        chk("t1_dev_latched", 32'(core_dev), 32'hA0);
        chk("t1_wdata_latched", 32'(core_wdata), 32'h5A);
        chk("t1_wr_held", 32'(core_wr_req), 32'd1);
        expect_ack(1, 1'b0);
        pulse_wr();
        chk("t1_req_drop", 32'(core_wr_req), 32'd0);
        cl_req[1] = 1'b0;
        wait_idle(400);

        // Single read from client 2
        set_client(2, 1'b1, 8'hA1, 8'h22, 8'h00);
        cl_req[2] = 1'b1;
        wait_req(10, cyc);
        chk("t2_rd_req", 32'(core_rd_req), 32'd1);
        chk("t2_wr_req", 32'(core_wr_req), 32'd0);
        chk("t2_dev", 32'(core_dev), 32'hA1);
        chk("t2_reg", 32'(core_reg), 32'h22);
        repeat (20) @(negedge clk);
        exp_rdata = 8'hC3;
        expect_ack(2, 1'b0);
        pulse_rd(8'hC3);
        chk("t2_rd_drop", 32'(core_rd_req), 32'd0);
        cl_req[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_rdata_hold", 32'(cl_rdata), 32'hC3);
        wait_idle(400);

        // Wrong done pulse on a write
        set_client(0, 1'b0, 8'hA0, 8'h01, 8'h11);
        cl_req[0] = 1'b1;
        wait_req(10, cyc);
        pulse_rd(8'hEE);
        repeat (4) @(negedge clk);
        chk("t3_wr_held", 32'(core_wr_req), 32'd1);
        chk("t3_rdata_kept", 32'(cl_rdata), 32'hC3);
        expect_ack(0, 1'b0);
        pulse_wr();
        chk("t3_req_drop", 32'(core_wr_req), 32'd0);
        cl_req[0] = 1'b0;
        wait_idle(400);

        // Round robin: all clients requesting from reset
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_client(i, 1'b0, 8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i));
        end
        cl_req = 4'hF;
        repeat (2) @(negedge clk);
        chk("t4_rdata_cleared", 32'(cl_rdata), 32'd0);
        rst = 1'b0;
        exp_rdata = 8'h00;
        wait_req(20, cyc);
        busy_low = 1'b0;
        for (int k = 0; k < 5; k++) begin
            c = k % N;
            chk("rr_owner", 32'(core_dev), 32'(8'h40 + c));
            expect_ack(c, 1'b0);
            pulse_wr();
            cl_req[c] = 1'b0;
            if (k < 4) begin
                @(negedge clk);
                if (!busy) busy_low = 1'b1;
                cl_req[c] = 1'b1;
                wait_req(400, cyc);
                chk("rr_gap_min", 32'(cyc + 1 >= GAP + 1), 32'd1);
                chk("rr_gap_max", 32'(cyc + 1 <= GAP + 2), 32'd1);
            end
        end
        cl_req = 4'h0;
        chk("rr_busy_through_gap", 32'(busy_low), 32'd0);
        wait_idle(400);

        // Reset while client 1 is BUSY, client 3 pending
        set_client(1, 1'b0, 8'hB1, 8'h31, 8'h71);
        set_client(3, 1'b1, 8'hB3, 8'h33, 8'h00);
        cl_req[1] = 1'b1;
        wait_req(10, cyc);
        chk("t5_owner", 32'(core_dev), 32'hB1);
        cl_req[3] = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        cl_req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_wr_req", 32'(core_wr_req), 32'd0);
        chk("t5_rd_req", 32'(core_rd_req), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_dev", 32'(core_dev), 32'd0);
        chk("t5_ack", 32'(cl_ack), 32'd0);
        wait_req(10, cyc);
        chk("t5_pending_granted", 32'(core_dev), 32'hB3);
        chk("t5_rd_req_after", 32'(core_rd_req), 32'd1);
        exp_rdata = 8'h3C;
        expect_ack(3, 1'b0);
        pulse_rd(8'h3C);
        cl_req[3] = 1'b0;
        wait_idle(400);

`ifdef I2C_ARB_TIMEOUT_EN
        // Core never answers: abort after TO cycles of BUSY
        set_client(2, 1'b1, 8'hC2, 8'h42, 8'h00);
        cl_req[2] = 1'b1;
        wait_req(10, cyc);
        set_client(0, 1'b0, 8'hC0, 8'h40, 8'h99);
        cl_req[0] = 1'b1;
        expect_ack(2, 1'b1);
        cyc = 0;
        while (cl_ack == 4'b0000 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_ack_seen", 32'(cl_ack != 4'b0000), 32'd1);
        chk("to_when_min", 32'(cyc >= TO - 2), 32'd1);
        chk("to_when_max", 32'(cyc <= TO), 32'd1);
        chk("to_req_drop", 32'(core_rd_req), 32'd0);
        cl_req[2] = 1'b0;
        wait_req(400, cyc);
        chk("to_gap_min", 32'(cyc >= GAP + 1), 32'd1);
        chk("to_next_owner", 32'(core_dev), 32'hC0);
        expect_ack(0, 1'b0);
        pulse_wr();
        cl_req[0] = 1'b0;
        wait_idle(400);
`endif

        repeat (5) @(negedge clk);
        chk("rd_wr_overlap", 32'(overlap), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
- Shares one I2C byte-transaction core among NUM_CLIENTS requesters using round-robin arbitration.
- Each client submits a complete command: write/read flag, device address, register address and write data.
- The arbiter latches the granted command, drives the core's level-held wr_req/rd_req until the core pulses wr_done/rd_done, then returns read data and status to the owning client.
- Sits between the system-side register/sensor agents and the I2C core.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..4); index width is 2 bits fixed.
- GAP_CYCLES, 125, idle clk cycles forced between core transactions (bus free time).
- TIMEOUT_CYCLES, 50000, max clk cycles BUSY may last before abort (TIMEOUT feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cl_req  in  NUM_CLIENTS  per-client request level; held until its cl_ack
- cl_rw  in  NUM_CLIENTS  per-client 1=read, 0=write
- cl_dev  in  8*NUM_CLIENTS  device address byte (R/W bit included), client i at [8i+7:8i]
- cl_reg  in  8*NUM_CLIENTS  register address byte
- cl_wdata  in  8*NUM_CLIENTS  write data byte
- cl_ack  out  NUM_CLIENTS  one-cycle completion pulse to owning client
- cl_err  out  1  valid with cl_ack; 1 = aborted (timeout)
- cl_rdata  out  8  read byte, valid with cl_ack on a read
- busy  out  1  high from grant until GAP ends
- core_wr_req  out  1  level to core, write transaction
- core_rd_req  out  1  level to core, read transaction
- core_dev  out  8  latched device address
- core_reg  out  8  latched register address
- core_wdata  out  8  latched write data
- core_wr_done  in  1  core write-complete pulse
- core_rd_done  in  1  core read-complete pulse
- core_rd_data  in  8  core read byte, valid on core_rd_done

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = 0 (client 0 has highest priority first).
- Synchronous reset asserted mid-transaction drops core_wr_req/core_rd_req next edge; the owning client gets no ack.
- IDLE:
  - If any cl_req is set, pick the first set bit searching from rr pointer upward with wrap.
  - Latch rw/dev/reg/wdata and the owner index; go to BUSY next cycle.
  - Grant decision to core request asserted = 2 cycles.
- BUSY:
  - core_wr_req = ~rw, core_rd_req = rw, held every cycle.
  - core_dev/reg/wdata are stable for the whole transaction.
  - Latched fields never change if the client alters its inputs after grant.
- Completion:
  - The matching done pulse (wr_done for write, rd_done for read) completes the transaction.
  - On completion, drop core req that same edge and capture core_rd_data into cl_rdata (read only).
  - Pulse cl_ack[owner] for 1 cycle with cl_err=0.
  - Set rr pointer = owner+1 mod NUM_CLIENTS; go to GAP.
  - A non-matching done pulse is ignored.
- GAP:
  - Count GAP_CYCLES cycles with core req low, then IDLE.
  - Requests arriving in GAP wait; busy stays high through GAP.
- cl_rdata holds its last value until the next read completion; it is 0 after reset.
- A client deasserting cl_req while BUSY does not cancel the transaction; the ack is still issued.
- A client must drop cl_req the cycle after its cl_ack. If it is still high in IDLE, it re-arbitrates as a new request at lowest priority (rr moved past it).
- Simultaneous requests from all clients: served in order owner+1, owner+2, … with no starvation. Each client waits at most NUM_CLIENTS-1 transactions.
- Bits of cl_req above NUM_CLIENTS-1 do not exist; the pointer wraps at NUM_CLIENTS-1.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - At TIMEOUT_CYCLES without a matching done, drop core req and pulse cl_ack[owner] with cl_err=1; cl_rdata is unchanged.
  - Advance rr pointer and enter GAP.
  - This covers the core returning to idle silently on NACK.
- Undefined:
  - No counter; BUSY waits indefinitely; cl_err is tied 0.

Test Plan:
- Single write: client 1 req, rw=0, dev=0xA0, reg=0x10, wdata=0x5A.
  - core_wr_req rises 2 cycles later with those values; core_wr_done after 100 cycles gives cl_ack[1] 1 cycle, cl_err=0, core_wr_req low the same edge.
- Single read: client 2, rw=1, dev=0xA1; core_rd_done with core_rd_data=0xC3.
  - cl_rdata=0xC3 with cl_ack[2]; core_rd_req never high with core_wr_req.
- Round robin: all 4 reqs held from reset.
  - Service order 0,1,2,3,0; busy remains high across GAP; each gap between core req fall and next rise ≥ GAP_CYCLES+1.
- Wrong done: BUSY on a write with a core_rd_done pulse injected.
  - No ack, core_wr_req stays high until core_wr_done.
- Reset mid-BUSY: rst for 1 cycle.
  - Next cycle all outputs 0, rr=0, no cl_ack; a pending client 3 is granted after rst deasserts.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=200): no done from core.
  - At cycle 200 of BUSY, core req drops and cl_ack[owner]=1 with cl_err=1; next client is served after GAP.
